fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding + load-use hazard unit for the 5-stage pipeline; supersedes the combinational 2-source forwarder.

---
 rtl/fwd_hazard_unit.sv | 97 +++++++++
 tb/tb_fwd_hazard_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use stall unit with in-flight destination tracking
module fwd_hazard_unit #(
    parameter int REG_W      = 5,
    parameter int NSRC       = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*REG_W-1:0]  id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC*SEL_W-1:0]  fw_sel,
    output logic [CNT_W-1:0]       stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             load;
    } entry_t;

    entry_t ex_q;
    entry_t p_q [FWD_DEPTH];

    logic [NSRC*SEL_W-1:0] sel_d;
    logic [NSRC-1:0]       load_hit;
    logic                  issue;

    function automatic logic writes(input entry_t e, input logic [REG_W-1:0] r);
        return e.valid && e.regwrite && (e.rd == r) && (r != '0);
    endfunction

    // Search youngest-first: EX, then p[0..FWD_DEPTH-2]; p[FWD_DEPTH-1] is covered by the regfile.
    always_comb begin
        sel_d    = '0;
        load_hit = '0;
        for (int i = 0; i < NSRC; i++) begin
            logic             found;
            logic [REG_W-1:0] r;
            found = 1'b0;
            r     = id_src[i*REG_W +: REG_W];
            if (id_src_used[i] && (r != '0)) begin
                if (writes(ex_q, r)) begin
                    found                    = 1'b1;
                    sel_d[i*SEL_W +: SEL_W]  = SEL_W'(FWD_DEPTH);
                    load_hit[i]              = ex_q.load;
                end
                for (int k = 0; k < FWD_DEPTH - 1; k++) begin
                    if (!found && writes(p_q[k], r)) begin
                        found                   = 1'b1;
                        sel_d[i*SEL_W +: SEL_W] = SEL_W'(FWD_DEPTH - k - 1);
                        load_hit[i]             = p_q[k].load && ((k + 1) < LOAD_STAGE);
                    end
                end
            end
        end
    end

    assign stall = id_valid && !flush && (|load_hit);
    assign issue = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            fw_sel    <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            p_q[0] <= ex_q;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                p_q[k] <= p_q[k-1];
            end
            if (issue) begin
                ex_q   <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, load: id_memread};
                fw_sel <= sel_d;
            end else begin
                ex_q   <= '0;
                fw_sel <= '0;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and random checks of fwd_hazard_unit against an age-based model
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;

    logic        stall_a, stall_b;
    logic [3:0]  sel_a, sel_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    fwd_hazard_unit dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .stall(stall_a),
        .fw_sel(sel_a), .stall_cnt(cnt_a)
    );

    fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_STAGE(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .stall(stall_b),
        .fw_sel(sel_b), .stall_cnt(cnt_b)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } ent_t;

    // hist[m][a]: instruction that entered EX a cycles ago (a=0 is the EX entry)
    ent_t hist [2][4];
    int   exp_sel [2][2];
    int   exp_cnt [2];
    int   checks = 0;
    int   errors = 0;
    logic obs_stall_a, obs_stall_b;

    function automatic int depth_of(int m);
        return (m == 0) ? 2 : 3;
    endfunction

    function automatic int lstage_of(int m);
        return (m == 0) ? 1 : 2;
    endfunction

    function automatic int cmax_of(int m);
        return (m == 0) ? 65535 : 3;
    endfunction

    function automatic int age_of(int m, logic [4:0] r);
        if (r == 5'd0) return -1;
        for (int a = 0; a < depth_of(m); a++) begin
            if (hist[m][a].v && hist[m][a].rw && hist[m][a].rd == r) return a;
        end
        return -1;
    endfunction

    function automatic logic model_stall(int m);
        if (!id_valid || flush) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            int a;
            a = age_of(m, id_src[i*5 +: 5]);
            if (id_src_used[i] && a >= 0 && hist[m][a].ld && a < lstage_of(m)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] u, input logic [4:0] d, input logic w,
                        input logic l, input logic fl, input logic r);
        logic ms [2];
        int   ns [2][2];
        id_valid = v; id_src = {s1, s0}; id_src_used = u; id_rd = d;
        id_regwrite = w; id_memread = l; flush = fl; rst = r;
        #1;
        for (int m = 0; m < 2; m++) begin
            ms[m] = model_stall(m);
            for (int i = 0; i < 2; i++) begin
                int a;
                a = age_of(m, id_src[i*5 +: 5]);
                ns[m][i] = (u[i] && a >= 0) ? depth_of(m) - a : 0;
            end
        end
        obs_stall_a = stall_a;
        obs_stall_b = stall_b;
        check("stall_a", {31'd0, stall_a}, {31'd0, ms[0]});
        check("stall_b", {31'd0, stall_b}, {31'd0, ms[1]});
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                for (int a = 0; a < 4; a++) hist[m][a] = '0;
                exp_sel[m][0] = 0; exp_sel[m][1] = 0; exp_cnt[m] = 0;
            end else begin
                logic iss;
                iss = v && !ms[m] && !fl;
                for (int a = 3; a > 0; a--) hist[m][a] = hist[m][a-1];
                hist[m][0] = '{v: iss, rd: d, rw: w, ld: l};
                for (int i = 0; i < 2; i++) exp_sel[m][i] = iss ? ns[m][i] : 0;
                if (ms[m] && exp_cnt[m] < cmax_of(m)) exp_cnt[m]++;
            end
        end
        check("sel_a0", {30'd0, sel_a[1:0]}, exp_sel[0][0]);
        check("sel_a1", {30'd0, sel_a[3:2]}, exp_sel[0][1]);
        check("sel_b0", {30'd0, sel_b[1:0]}, exp_sel[1][0]);
        check("sel_b1", {30'd0, sel_b[3:2]}, exp_sel[1][1]);
        check("cnt_a", {16'd0, cnt_a}, exp_cnt[0]);
        check("cnt_b", {30'd0, cnt_b}, exp_cnt[1]);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // op helpers: producer with no sources, consumer reading src0
    task automatic prod(input logic [4:0] d, input logic l);
        step(1'b1, 5'd0, 5'd0, 2'b00, d, 1'b1, l, 1'b0, 1'b0);
    endtask

    task automatic use0(input logic [4:0] s, input logic fl, input logic r);
        step(1'b1, s, 5'd0, 2'b01, 5'd9, 1'b0, 1'b0, fl, r);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 4; a++) hist[m][a] = '0;
            exp_sel[m][0] = 0; exp_sel[m][1] = 0; exp_cnt[m] = 0;
        end
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_sel_a", {28'd0, sel_a}, 32'd0);
        check("reset_cnt_a", {16'd0, cnt_a}, 32'd0);
        check("reset_stall_a", {31'd0, stall_a}, 32'd0);

        prod(5'd3, 1'b0);
        use0(5'd3, 1'b0, 1'b0);
        check("t1_stall", {31'd0, obs_stall_a}, 32'd0);
        check("t1_sel", {30'd0, sel_a[1:0]}, 32'd2);
        nops(5);

        prod(5'd3, 1'b0); nops(1); use0(5'd3, 1'b0, 1'b0);
        check("t2_gap1_sel", {30'd0, sel_a[1:0]}, 32'd1);
        nops(5);
        prod(5'd3, 1'b0); nops(3); use0(5'd3, 1'b0, 1'b0);
        check("t2_gap3_sel", {30'd0, sel_a[1:0]}, 32'd0);
        nops(5);

        prod(5'd5, 1'b1); use0(5'd5, 1'b0, 1'b0);
        check("t3_stall", {31'd0, obs_stall_a}, 32'd1);
        check("t3_bubble_sel", {30'd0, sel_a[1:0]}, 32'd0);
        check("t3_cnt", {16'd0, cnt_a}, 32'd1);
        use0(5'd5, 1'b0, 1'b0);
        check("t3_after_stall", {31'd0, obs_stall_a}, 32'd0);
        check("t3_sel", {30'd0, sel_a[1:0]}, 32'd1);
        nops(5);

        prod(5'd4, 1'b0); prod(5'd4, 1'b1); use0(5'd4, 1'b0, 1'b0);
        check("t4_stall", {31'd0, obs_stall_a}, 32'd1);
        use0(5'd4, 1'b0, 1'b0);
        check("t4_sel_load", {30'd0, sel_a[1:0]}, 32'd1);
        prod(5'd0, 1'b0); use0(5'd0, 1'b0, 1'b0);
        check("t4_r0_sel", {30'd0, sel_a[1:0]}, 32'd0);
        nops(5);

        prod(5'd7, 1'b1); use0(5'd7, 1'b1, 1'b0);
        check("t5_flush_stall", {31'd0, obs_stall_a}, 32'd0);
        check("t5_flush_sel", {30'd0, sel_a[1:0]}, 32'd0);
        nops(5);
        prod(5'd7, 1'b1); use0(5'd7, 1'b0, 1'b1);
        check("t5_rst_stall_before", {31'd0, obs_stall_a}, 32'd1);
        use0(5'd7, 1'b0, 1'b0);
        check("t5_rst_stall_after", {31'd0, obs_stall_a}, 32'd0);
        check("t5_rst_cnt", {16'd0, cnt_a}, 32'd0);
        nops(5);

        prod(5'd2, 1'b1);
        use0(5'd2, 1'b0, 1'b0);
        check("t6_stall1", {31'd0, obs_stall_b}, 32'd1);
        use0(5'd2, 1'b0, 1'b0);
        check("t6_stall2", {31'd0, obs_stall_b}, 32'd1);
        use0(5'd2, 1'b0, 1'b0);
        check("t6_stall3", {31'd0, obs_stall_b}, 32'd0);
        check("t6_sel", {30'd0, sel_b[1:0]}, 32'd1);
        check("t6_cnt", {30'd0, cnt_b}, 32'd2);
        nops(5);
        prod(5'd2, 1'b1); use0(5'd2, 1'b0, 1'b0); use0(5'd2, 1'b0, 1'b0); use0(5'd2, 1'b0, 1'b0);
        check("t6_cnt_sat", {30'd0, cnt_b}, 32'd3);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
